// File: rtl/cont_serializer_if.sv
// Handshake bundle between a wide producer, the serializer and a narrow consumer.
// The serializer takes the slave side; whoever drives words and accepts beats takes master.
interface cont_serializer_if #(
  parameter int WIDTH = 128,
  parameter int BEAT  = 32
);
  localparam int NBEATS = WIDTH / BEAT;
  localparam int IDX_W  = $clog2(NBEATS);

  // valid/ready: a transfer happens on a rising edge where both are 1; a
  // sender holding valid keeps its payload stable until ready is seen.
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [BEAT-1:0]  out_data;
  logic             out_cont;
  logic [IDX_W-1:0] out_idx;
  logic             dbg_state;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_cont, out_idx, dbg_state
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_cont, out_idx, dbg_state
  );
endinterface

// File: rtl/cont_serializer.sv
// Splits WIDTH-bit words into NBEATS narrow beats, LSB first, with a
// continuation flag on every beat except the last of each word.
module cont_serializer #(
  parameter int WIDTH = 128,
  parameter int BEAT  = 32
) (
  input logic            clk,
  input logic            rst_n,
  cont_serializer_if.slave bus
);
  localparam int NBEATS = WIDTH / BEAT;
  localparam int IDX_W  = $clog2(NBEATS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBEATS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] buf_q, buf_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             last_beat;
  logic             in_ready_c;

  assign last_beat  = (idx_q == LAST_IDX);
  // The only combinational input-to-output path: out_ready opens the input on the last beat.
  assign in_ready_c = (state_q == IDLE) || (last_beat && bus.out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      buf_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = SEND;
          buf_d   = bus.in_data;
          idx_d   = '0;
        end
      end
      SEND: begin
        if (bus.out_ready) begin
          if (!last_beat) begin
            idx_d = idx_q + 1'b1;
          end else if (bus.in_valid) begin
            buf_d = bus.in_data;
            idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = in_ready_c;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.out_cont  = 1'b0;
    bus.out_idx   = '0;
    bus.dbg_state = state_q;
    if (state_q == SEND) begin
      bus.out_valid = 1'b1;
      bus.out_data  = buf_q[int'(idx_q)*BEAT +: BEAT];
      bus.out_cont  = !last_beat;
      bus.out_idx   = idx_q;
    end
  end
endmodule

// File: tb/tb_cont_serializer.sv
// Directed bench for cont_serializer: 128/32 instance for the main scenarios,
// 64/8 instance for the narrow-beat variant.
module tb_cont_serializer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  logic [127:0] exp_q[$];

  always #5 clk = ~clk;

  cont_serializer_if #(.WIDTH(128), .BEAT(32)) bus ();
  cont_serializer_if #(.WIDTH(64),  .BEAT(8))  bus8 ();

  cont_serializer #(.WIDTH(128), .BEAT(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  cont_serializer #(.WIDTH(64), .BEAT(8)) dut8 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus8.slave)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] beat32(input logic [127:0] w, input int b);
    return w[b*32 +: 32];
  endfunction

  // Checks every output of the 128/32 instance for one shown beat.
  task automatic check_beat(input string tag, input logic [31:0] data, input int idx,
                            input logic rdy);
    check({tag, "_valid"}, 128'(bus.out_valid), 128'(1));
    check({tag, "_data"},  128'(bus.out_data),  128'(data));
    check({tag, "_idx"},   128'(bus.out_idx),   128'(idx));
    check({tag, "_cont"},  128'(bus.out_cont),  128'(idx != 3));
    check({tag, "_rdy"},   128'(bus.in_ready),  128'(rdy));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, 128'(bus.out_valid), 128'(0));
    check({tag, "_data"},  128'(bus.out_data),  128'(0));
    check({tag, "_idx"},   128'(bus.out_idx),   128'(0));
    check({tag, "_cont"},  128'(bus.out_cont),  128'(0));
    check({tag, "_rdy"},   128'(bus.in_ready),  128'(1));
  endtask

  // Offers a word while idle and lets it be taken on the next edge.
  task automatic accept_word(input logic [127:0] w);
    bus.in_valid  = 1'b1;
    bus.in_data   = w;
    bus.out_ready = 1'b1;
    #1;
    check("accept_rdy", 128'(bus.in_ready), 128'(1));
    tick();
    bus.in_valid = 1'b0;
    bus.in_data  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] wa, wb, wc, wd, we, wf, wg;
    logic [63:0]  w8;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.out_ready  = 1'b0;
    bus8.in_valid  = 1'b0;
    bus8.in_data   = '0;
    bus8.out_ready = 1'b0;

    // Reset state, released between edges
    #12;
    check_idle("reset");
    #5 rst_n = 1'b1;
    tick();
    check_idle("post_reset");

    // Single word
    accept_word(128'h33333333_22222222_11111111_00000000);
    check_beat("single_b0", 32'h00000000, 0, 1'b0); tick();
    check_beat("single_b1", 32'h11111111, 1, 1'b0); tick();
    check_beat("single_b2", 32'h22222222, 2, 1'b0); tick();
    check_beat("single_b3", 32'h33333333, 3, 1'b1); tick();
    check_idle("single_done");

    // Back-to-back: B accepted on A's last beat, 8 beats with no gap
    wa = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
    wb = 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0;
    for (int b = 0; b < 4; b++) exp_q.push_back(128'(beat32(wa, b)));
    for (int b = 0; b < 4; b++) exp_q.push_back(128'(beat32(wb, b)));
    bus.in_valid  = 1'b1;
    bus.in_data   = wa;
    bus.out_ready = 1'b1;
    tick();
    for (int n = 0; n < 8; n++) begin
      if (n == 3) bus.in_data = wb;
      if (n == 4) bus.in_valid = 1'b0;
      #1;
      check("b2b_valid", 128'(bus.out_valid), 128'(1));
      check("b2b_data", 128'(bus.out_data), exp_q.pop_front());
      check("b2b_idx", 128'(bus.out_idx), 128'(n % 4));
      if (n == 3) check("b2b_accept_rdy", 128'(bus.in_ready), 128'(1));
      tick();
    end
    check_idle("b2b_done");

    // Backpressure on beat 1; pending input must be refused and ignored
    wc = 128'hC0DE0003_C0DE0002_C0DE0001_C0DE0000;
    accept_word(wc);
    check_beat("bp_b0", beat32(wc, 0), 0, 1'b0); tick();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int s = 0; s < 5; s++) begin
      bus.in_data = {$urandom, $urandom, $urandom, $urandom};
      #1;
      check_beat("bp_stall", beat32(wc, 1), 1, 1'b0);
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check_beat("bp_b1", beat32(wc, 1), 1, 1'b0); tick();
    check_beat("bp_b2", beat32(wc, 2), 2, 1'b0); tick();
    check_beat("bp_b3", beat32(wc, 3), 3, 1'b1); tick();
    check_idle("bp_done");

    // Last-beat stall with a word pending
    wd = 128'hD3D3D3D3_D2D2D2D2_D1D1D1D1_D0D0D0D0;
    we = 128'hE3E3E3E3_E2E2E2E2_E1E1E1E1_E0E0E0E0;
    accept_word(wd);
    tick(); tick(); tick();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = we;
    for (int s = 0; s < 3; s++) begin
      #1;
      check_beat("lst_stall", beat32(wd, 3), 3, 1'b0);
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    check_beat("lst_release", beat32(wd, 3), 3, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      #1;
      check_beat("lst_next", beat32(we, b), b, b == 3);
      tick();
    end
    check_idle("lst_done");

    // Asynchronous reset mid-word
    wf = 128'hF3F3F3F3_F2F2F2F2_F1F1F1F1_F0F0F0F0;
    wg = 128'h9A3A3A3A_9A2A2A2A_9A1A1A1A_9A0A0A0A;
    accept_word(wf);
    tick();
    check_beat("ar_b1", beat32(wf, 1), 1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_idle("ar_asserted");
    #2 rst_n = 1'b1;
    tick();
    check_idle("ar_after1");
    tick();
    check_idle("ar_after2");
    accept_word(wg);
    check_beat("ar_next_b0", beat32(wg, 0), 0, 1'b0);
    bus.out_ready = 1'b0;

    // 64/8 variant
    w8 = 64'h0706050403020100;
    bus8.in_valid  = 1'b1;
    bus8.in_data   = w8;
    bus8.out_ready = 1'b1;
    #1;
    check("v8_accept_rdy", 128'(bus8.in_ready), 128'(1));
    tick();
    bus8.in_valid = 1'b0;
    for (int b = 0; b < 8; b++) begin
      #1;
      check("v8_valid", 128'(bus8.out_valid), 128'(1));
      check("v8_data", 128'(bus8.out_data), 128'(b));
      check("v8_idx", 128'(bus8.out_idx), 128'(b));
      check("v8_cont", 128'(bus8.out_cont), 128'(b != 7));
      tick();
    end
    check("v8_done_valid", 128'(bus8.out_valid), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
